// File: rtl/demux18_deser.sv
// demux18_deser: routes serial bits into an 8-bit parallel word.
// Bits are placed by an internal sequential counter or by an explicit index.
// A frame completes when all eight positions have been written. It is then
// held until the consumer accepts it.
module demux18_deser #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       addr_mode,
  input  logic [2:0] sel,
  input  logic       clr,
  output logic [7:0] out_data,
  output logic [7:0] out_mask,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [2:0] CNT_START = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] CNT_STEP  = (LSB_FIRST != 0) ? 3'd1 : 3'd7;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] idx;
  logic       accept;
  logic       handshake;
  logic [7:0] mask_set;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign idx       = addr_mode ? sel : cnt;
  assign mask_set  = out_mask | (8'd1 << idx);

  // State register: COLLECT while filling, HOLD while a full frame waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: clr dominates, then completion, then the output handshake.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && (mask_set == 8'hFF)) state_nxt = HOLD;
        HOLD:    if (handshake) state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  // Handshake outputs depend only on the registered state.
  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = (state == COLLECT);
  end

  // Frame datapath: write on accept, restart the frame on clr or handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 8'h00;
      out_mask <= 8'h00;
      cnt      <= CNT_START;
    end else if (clr) begin
      out_mask <= 8'h00;
      cnt      <= CNT_START;
    end else if (accept) begin
      out_data[idx] <= in_bit;
      out_mask      <= mask_set;
      if (!addr_mode) begin
        cnt <= cnt + CNT_STEP;
      end
    end else if (handshake) begin
      out_mask <= 8'h00;
      cnt      <= CNT_START;
    end
  end

endmodule

// File: tb/tb_demux18_deser.sv
// Bench for demux18_deser: two instances (LSB-first and MSB-first) share the
// same stimulus and are compared each cycle against a frame-level model.
module tb_demux18_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_bit, in_valid, addr_mode, clr, out_ready;
  logic [2:0] sel;
  logic       a_ready, a_valid, b_ready, b_valid;
  logic [7:0] a_data, a_mask, b_data, b_mask;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state, index 0 = LSB-first instance, 1 = MSB-first instance
  logic [7:0] md[2];
  logic [7:0] mm[2];
  int         mpos[2];
  bit         mh[2];

  always #5 clk = ~clk;

  demux18_deser #(.LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(a_ready), .addr_mode(addr_mode), .sel(sel), .clr(clr),
    .out_data(a_data), .out_mask(a_mask), .out_valid(a_valid),
    .out_ready(out_ready));

  demux18_deser #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(b_ready), .addr_mode(addr_mode), .sel(sel), .clr(clr),
    .out_data(b_data), .out_mask(b_mask), .out_valid(b_valid),
    .out_ready(out_ready));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level reference: position counter per instance, mask decides completion
  task automatic model_edge();
    logic [2:0] idx;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        mm[k] = 8'h00; mpos[k] = 0; mh[k] = 1'b0;
      end else if (!mh[k]) begin
        if (in_valid) begin
          if (addr_mode) idx = sel;
          else if (k == 0) idx = 3'(mpos[k] % 8);
          else idx = 3'(7 - (mpos[k] % 8));
          md[k][idx] = in_bit;
          mm[k][idx] = 1'b1;
          if (!addr_mode) mpos[k]++;
          if (mm[k] == 8'hFF) mh[k] = 1'b1;
        end
      end else if (out_ready) begin
        mm[k] = 8'h00; mpos[k] = 0; mh[k] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 8'h00; mm[k] = 8'h00; mpos[k] = 0; mh[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic b, input logic am, input logic [2:0] s,
                        input logic c, input logic r);
    in_valid = v; in_bit = b; addr_mode = am; sel = s; clr = c; out_ready = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_a_data", a_data, 8'h00);
    chk("rst_a_mask", a_mask, 8'h00);
    chk("rst_a_valid", {7'd0, a_valid}, 8'd0);
    chk("rst_a_ready", {7'd0, a_ready}, 8'd1);
    chk("rst_b_mask", b_mask, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_a_data", a_data, md[0]);
      chk("cyc_a_mask", a_mask, mm[0]);
      chk("cyc_a_valid", {7'd0, a_valid}, {7'd0, mh[0]});
      chk("cyc_a_ready", {7'd0, a_ready}, {7'd0, !mh[0]});
      chk("cyc_b_data", b_data, md[1]);
      chk("cyc_b_mask", b_mask, mm[1]);
      chk("cyc_b_valid", {7'd0, b_valid}, {7'd0, mh[1]});
      chk("cyc_b_ready", {7'd0, b_ready}, {7'd0, !mh[1]});
    end
  end

  initial begin
    logic [2:0] order[7];
    rst_n = 1'b0;
    set_in(0, 0, 0, 3'd0, 0, 0);
    model_reset();
    #2;
    do_reset();
    chk_en = 1'b1;

    // sequential fill, alternating bits, no consumer
    for (int i = 0; i < 8; i++) begin
      set_in(1, 1'(i % 2), 0, 3'd0, 0, 0);
      tick();
    end
    chk("seq_a_data", a_data, 8'hAA);
    chk("seq_a_mask", a_mask, 8'hFF);
    chk("seq_a_valid", {7'd0, a_valid}, 8'd1);
    chk("seq_a_ready", {7'd0, a_ready}, 8'd0);
    chk("seq_model_data", md[0], 8'hAA);
    chk("seq_b_data", b_data, 8'h55);

    // backpressure: held frame ignores toggling input
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1'(i % 2), 0, 3'd0, 0, 0);
      tick();
    end
    chk("bp_a_data", a_data, 8'hAA);
    set_in(1, 1, 0, 3'd0, 0, 1);
    tick();
    chk("hs_a_valid", {7'd0, a_valid}, 8'd0);
    chk("hs_a_mask", a_mask, 8'h00);
    chk("hs_a_data", a_data, 8'hAA);
    set_in(1, 1, 0, 3'd0, 0, 0);
    tick();
    chk("first_after_hs_mask", a_mask, 8'h01);
    chk("first_after_hs_data", a_data, 8'hAB);

    // abort partial frame, then addressed fill
    set_in(0, 0, 0, 3'd0, 1, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_in(1, (i < 4) ? 1'b1 : 1'b0, 1, 3'(i), 0, 0);
      tick();
    end
    chk("addr_a_data", a_data, 8'h0F);
    chk("addr_a_valid", {7'd0, a_valid}, 8'd1);
    set_in(0, 0, 0, 3'd0, 0, 1);
    tick();
    chk("addr_rel_valid", {7'd0, a_valid}, 8'd0);
    chk("addr_rel_mask", a_mask, 8'h00);
    chk("addr_rel_data", a_data, 8'h0F);

    // overwrite of index 3; completion only on the ninth accept
    set_in(1, 1, 1, 3'd3, 0, 0); tick();
    set_in(1, 0, 1, 3'd3, 0, 0); tick();
    order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 7; i++) begin
      set_in(1, 1, 1, order[i], 0, 0);
      if (i == 6) chk("ow_not_done", {7'd0, a_valid}, 8'd0);
      tick();
    end
    chk("ow_a_data", a_data, 8'hF7);
    chk("ow_a_valid", {7'd0, a_valid}, 8'd1);
    set_in(0, 0, 0, 3'd0, 0, 1); tick();

    // asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 3'd0, 0, 0); tick();
    end
    do_reset();

    // clr with a valid bit pending: bit dropped, counter restarts
    for (int i = 0; i < 4; i++) begin
      set_in(1, (i == 1) ? 1'b0 : 1'b1, 0, 3'd0, 0, 0); tick();
    end
    set_in(1, 1, 0, 3'd0, 1, 0); tick();
    chk("clr_a_mask", a_mask, 8'h00);
    chk("clr_a_data", a_data, 8'h0D);
    set_in(1, 0, 0, 3'd0, 0, 0); tick();
    chk("clr_restart_mask", a_mask, 8'h01);
    chk("clr_restart_data", a_data, 8'h0C);

    // MSB-first ordering
    set_in(0, 0, 0, 3'd0, 1, 0); tick();
    for (int i = 0; i < 8; i++) begin
      set_in(1, (i == 0) ? 1'b1 : 1'b0, 0, 3'd0, 0, 0); tick();
    end
    chk("msb_b_data", b_data, 8'h80);
    chk("msb_b_valid", {7'd0, b_valid}, 8'd1);
    chk("msb_a_data", a_data, 8'h01);
    set_in(0, 0, 0, 3'd0, 0, 1); tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             3'($urandom), 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) == 0));
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
